text_lcd_bus_decoder: RTL and testbench

Receiving end of the text LCD bus: watches lcd_e/lcd_rs/lcd_rw/lcd_data as driven by text_lcd_display, decodes HD44780-style commands and data writes, and rebuilds the 2×16 visible character buffer plus the cursor address. It sits beside the display driver in simulation and on-board as a readback/self-check path, so main_logic's line1_text/line2_text/ddram_address intent can be compared against what actually went out on the pins.

---
 rtl/text_lcd_bus_decoder_pkg.sv | 54 +++++
 rtl/text_lcd_bus_decoder_sync.sv | 46 ++++
 rtl/text_lcd_bus_decoder.sv | 152 +++++++++++++++
 tb/tb_text_lcd_bus_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_lcd_bus_decoder_pkg.sv
// Shared constants, types and address-stepping helper for the text LCD bus decoder.
package text_lcd_bus_decoder_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned LINE_CHARS = 16;
    localparam int unsigned NUM_CHARS  = 2 * LINE_CHARS;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned LINE_W     = LINE_CHARS * DATA_W;

    localparam logic [DATA_W-1:0] CMD_CLEAR    = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME     = 8'h02;
    localparam logic [DATA_W-1:0] CMD_ENTRY    = 8'h04;
    localparam logic [DATA_W-1:0] CMD_DISPLAY  = 8'h08;
    localparam logic [DATA_W-1:0] CMD_SHIFT    = 8'h10;
    localparam logic [DATA_W-1:0] CMD_FUNCTION = 8'h20;
    localparam logic [DATA_W-1:0] CMD_CGRAM    = 8'h40;
    localparam logic [DATA_W-1:0] CMD_DDRAM    = 8'h80;

    localparam logic [DATA_W-1:0] SPACE = 8'h20;

    localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] LINE2_BASE = 7'h40;
    localparam logic [ADDR_W-1:0] LINE1_END  = 7'h27;
    localparam logic [ADDR_W-1:0] LINE2_END  = 7'h67;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic              e;
        logic              rs;
        logic              rw;
        logic [DATA_W-1:0] data;
    } lcd_bus_t;

    // Address counter step with two-line wrap; other addresses step modulo 128.
    function automatic logic [ADDR_W-1:0] step_ac(input logic [ADDR_W-1:0] ac, input logic inc);
        logic [ADDR_W-1:0] nxt;
        if (inc) begin
            if (ac == LINE1_END)      nxt = LINE2_BASE;
            else if (ac == LINE2_END) nxt = LINE1_BASE;
            else                      nxt = ac + ADDR_W'(1);
        end else begin
            if (ac == LINE1_BASE)      nxt = LINE2_END;
            else if (ac == LINE2_BASE) nxt = LINE1_END;
            else                       nxt = ac - ADDR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/text_lcd_bus_decoder_sync.sv
// Input synchronizer for the LCD bus plus falling-edge detect on e.
// The extra pipeline stage holds the bus as it was while e was still high.
module lcd_bus_sync
    import text_lcd_bus_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_e,
    input  logic              i_rs,
    input  logic              i_rw,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_event_c,
    output logic              o_rs_c,
    output logic              o_rw_c,
    output logic [DATA_W-1:0] o_data_c
);

    localparam int DEPTH = int'(SYNC_STAGES) + 1;

    lcd_bus_t w_in;
    lcd_bus_t r_pipe [DEPTH];

    always_comb begin
        w_in.e    = i_e;
        w_in.rs   = i_rs;
        w_in.rw   = i_rw;
        w_in.data = i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_event_c = r_pipe[DEPTH-1].e & ~r_pipe[DEPTH-2].e;
    assign o_rs_c    = r_pipe[DEPTH-1].rs;
    assign o_rw_c    = r_pipe[DEPTH-1].rw;
    assign o_data_c  = r_pipe[DEPTH-1].data;

endmodule

// File: rtl/text_lcd_bus_decoder.sv
// Snoops the text LCD bus, decodes HD44780-style commands/data writes and
// rebuilds the 2x16 visible character buffer and address counter.
module text_lcd_bus_decoder
    import text_lcd_bus_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lcd_e,
    input  logic                lcd_rs,
    input  logic                lcd_rw,
    input  logic [DATA_W-1:0]   lcd_data,
    output logic [LINE_W-1:0]   line1_text,
    output logic [LINE_W-1:0]   line2_text,
    output logic [ADDR_W-1:0]   ddram_address,
    output logic                display_on,
    output logic                busy,
    output logic                cmd_strobe,
    output logic                data_strobe,
    output logic                overrun
);

    logic              w_event;
    logic              w_rs;
    logic              w_rw;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    logic              w_cmd;
    logic              w_wr;
    logic              w_clear_cmd;
    state_e            w_state_nxt;

    state_e            r_state;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [DATA_W-1:0] r_text [NUM_CHARS];
    logic [ADDR_W-1:0] r_ac;
    logic              r_inc;
    logic              r_cgram;
    logic              r_display_on;
    logic              r_cmd_strobe;
    logic              r_data_strobe;
    logic              r_overrun;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_e       (lcd_e),
        .i_rs      (lcd_rs),
        .i_rw      (lcd_rw),
        .i_data    (lcd_data),
        .o_event_c (w_event),
        .o_rs_c    (w_rs),
        .o_rw_c    (w_rw),
        .o_data_c  (w_data)
    );

    assign w_cmd       = w_event & ~w_busy & ~w_rw & ~w_rs;
    assign w_wr        = w_event & ~w_busy & ~w_rw &  w_rs;
    assign w_clear_cmd = w_cmd & (w_data == CMD_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_clear_cmd) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_idx == IDX_W'(NUM_CHARS - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_CLEAR);
    end

    // Datapath: clear sweep, command decode (highest set bit wins) and data writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CHARS); i++) r_text[i] <= SPACE;
            r_clr_idx     <= '0;
            r_ac          <= '0;
            r_inc         <= 1'b1;
            r_cgram       <= 1'b0;
            r_display_on  <= 1'b0;
            r_cmd_strobe  <= 1'b0;
            r_data_strobe <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cmd_strobe  <= w_cmd;
            r_data_strobe <= w_wr;

            if (w_busy) begin
                r_text[r_clr_idx] <= SPACE;
                r_clr_idx         <= r_clr_idx + IDX_W'(1);
                if (w_event) r_overrun <= 1'b1;
            end

            if (w_cmd) begin
                if (|(w_data & CMD_DDRAM)) begin
                    r_ac    <= w_data[ADDR_W-1:0];
                    r_cgram <= 1'b0;
                end else if (|(w_data & CMD_CGRAM)) begin
                    r_cgram <= 1'b1;
                end else if (|(w_data & CMD_FUNCTION)) begin
                    r_cgram <= r_cgram;
                end else if (|(w_data & CMD_SHIFT)) begin
                    if (!w_data[3]) r_ac <= step_ac(r_ac, w_data[2]);
                end else if (|(w_data & CMD_DISPLAY)) begin
                    r_display_on <= w_data[2];
                end else if (|(w_data & CMD_ENTRY)) begin
                    r_inc <= w_data[1];
                end else if (|(w_data & CMD_HOME)) begin
                    r_ac <= '0;
                end else if (|(w_data & CMD_CLEAR)) begin
                    r_ac      <= '0;
                    r_inc     <= 1'b1;
                    r_cgram   <= 1'b0;
                    r_clr_idx <= '0;
                end
            end

            if (w_wr && !r_cgram) begin
                if (r_ac[6:4] == 3'b000)      r_text[{1'b0, r_ac[3:0]}] <= w_data;
                else if (r_ac[6:4] == 3'b100) r_text[{1'b1, r_ac[3:0]}] <= w_data;
                r_ac <= step_ac(r_ac, r_inc);
            end
        end
    end

    always_comb begin
        line1_text = '0;
        line2_text = '0;
        for (int k = 0; k < int'(LINE_CHARS); k++) begin
            line1_text[(int'(LINE_CHARS) - 1 - k) * int'(DATA_W) +: DATA_W] = r_text[k];
            line2_text[(int'(LINE_CHARS) - 1 - k) * int'(DATA_W) +: DATA_W] = r_text[k + int'(LINE_CHARS)];
        end
    end

    assign ddram_address = r_ac;
    assign display_on    = r_display_on;
    assign busy          = w_busy;
    assign cmd_strobe    = r_cmd_strobe;
    assign data_strobe   = r_data_strobe;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_text_lcd_bus_decoder.sv
// Self-checking bench for text_lcd_bus_decoder: strobe scoreboard plus per-scenario checks.
module tb_text_lcd_bus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic [127:0] line1_text;
    logic [127:0] line2_text;
    logic [6:0]   ddram_address;
    logic         display_on;
    logic         busy;
    logic         cmd_strobe;
    logic         data_strobe;
    logic         overrun;

    int checks   = 0;
    int failures = 0;
    int n_data   = 0;

    typedef struct packed {
        logic       is_data;
        logic [6:0] ac;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] ALL_SP = {16{8'h20}};
    localparam logic [55:0]  VEND   = "VENDING";

    always #5 clk = ~clk;

    text_lcd_bus_decoder #(
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_e         (lcd_e),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_data      (lcd_data),
        .line1_text    (line1_text),
        .line2_text    (line2_text),
        .ddram_address (ddram_address),
        .display_on    (display_on),
        .busy          (busy),
        .cmd_strobe    (cmd_strobe),
        .data_strobe   (data_strobe),
        .overrun       (overrun)
    );

    // Scoreboard: every strobe pops the expected kind and post-transfer address.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (cmd_strobe || data_strobe)) begin
            checks++;
            if (data_strobe) n_data++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected: got data=%0b ac=%h, required no strobe", data_strobe, ddram_address);
            end else begin
                e = sb.pop_front();
                if ({data_strobe, ddram_address} !== {e.is_data, e.ac}) begin
                    failures++;
                    $display("FAIL strobe_ac: got data=%0b ac=%h, required data=%0b ac=%h",
                             data_strobe, ddram_address, e.is_data, e.ac);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic is_data, input logic [6:0] ac);
        exp_t e;
        e.is_data = is_data;
        e.ac      = ac;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic xfer(input logic rs, input logic [7:0] d);
        pulse(rs, 1'b0, d);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_busy(input logic level, output logic ok);
        int n = 0;
        while (busy !== level && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === level);
    endtask

    task automatic test_reset();
        rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({line1_text, line2_text} !== {ALL_SP, ALL_SP}) begin
            failures++; $display("FAIL reset_text: got %h %h, required all 20", line1_text, line2_text);
        end
        checks++;
        if ({ddram_address, display_on, busy, cmd_strobe, data_strobe, overrun} !== 12'h000) begin
            failures++;
            $display("FAIL reset_ctrl: got ac=%h on=%b busy=%b cs=%b ds=%b ov=%b, required all 0",
                     ddram_address, display_on, busy, cmd_strobe, data_strobe, overrun);
        end
    endtask

    task automatic test_init();
        logic ok;
        int   cnt = 0;
        push(1'b0, 7'h00); xfer(1'b0, 8'h38);
        push(1'b0, 7'h00); xfer(1'b0, 8'h0C);
        push(1'b0, 7'h00); xfer(1'b0, 8'h06);
        push(1'b0, 7'h00); pulse(1'b0, 1'b0, 8'h01);
        wait_busy(1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL clear_start: busy got %b, required 1", busy); end
        while (busy === 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 32) begin failures++; $display("FAIL clear_busy_len: got %0d cycles, required 32", cnt); end
        checks++;
        if (display_on !== 1'b1) begin failures++; $display("FAIL init_display_on: got %b, required 1", display_on); end
        checks++;
        if ({line1_text, line2_text, ddram_address, overrun} !== {ALL_SP, ALL_SP, 7'h00, 1'b0}) begin
            failures++; $display("FAIL init_state: got ac=%h ov=%b l1=%h, required ac=00 ov=0 spaces", ddram_address, overrun, line1_text);
        end
    endtask

    task automatic test_vending();
        logic [7:0] v [7] = '{8'h56, 8'h45, 8'h4E, 8'h44, 8'h49, 8'h4E, 8'h47};
        int n0;
        push(1'b0, 7'h00); xfer(1'b0, 8'h80);
        n0 = n_data;
        for (int i = 0; i < 7; i++) begin
            push(1'b1, 7'(i + 1));
            xfer(1'b1, v[i]);
        end
        checks++;
        if (n_data - n0 !== 7) begin failures++; $display("FAIL vend_strobes: got %0d, required 7", n_data - n0); end
        checks++;
        if (line1_text !== {VEND, {9{8'h20}}}) begin
            failures++; $display("FAIL vend_line1: got %h, required %h", line1_text, {VEND, {9{8'h20}}});
        end
        checks++;
        if (ddram_address !== 7'h07) begin failures++; $display("FAIL vend_ac: got %h, required 07", ddram_address); end
    endtask

    task automatic test_line_end();
        push(1'b0, 7'h4F); xfer(1'b0, 8'hCF);
        push(1'b1, 7'h50); xfer(1'b1, 8'h41);
        push(1'b1, 7'h51); xfer(1'b1, 8'h42);
        checks++;
        if (line2_text !== {{15{8'h20}}, 8'h41}) begin
            failures++; $display("FAIL end_line2: got %h, required %h", line2_text, {{15{8'h20}}, 8'h41});
        end
        checks++;
        if (ddram_address !== 7'h51) begin failures++; $display("FAIL end_ac: got %h, required 51", ddram_address); end
    endtask

    task automatic test_decrement();
        logic [127:0] exp_l2 = {8'h58, {14{8'h20}}, 8'h41};
        push(1'b0, 7'h51); xfer(1'b0, 8'h04);
        push(1'b0, 7'h40); xfer(1'b0, 8'hC0);
        push(1'b1, 7'h27); xfer(1'b1, 8'h58);
        push(1'b1, 7'h26); xfer(1'b1, 8'h59);
        checks++;
        if (line2_text !== exp_l2) begin failures++; $display("FAIL dec_line2: got %h, required %h", line2_text, exp_l2); end
        checks++;
        if (ddram_address !== 7'h26) begin failures++; $display("FAIL dec_ac: got %h, required 26", ddram_address); end
        push(1'b0, 7'h26); xfer(1'b0, 8'h06);
        push(1'b0, 7'h27); xfer(1'b0, 8'hA7);
        push(1'b1, 7'h40); xfer(1'b1, 8'h57);
        checks++;
        if ({ddram_address, line2_text, line1_text} !== {7'h40, exp_l2, VEND, {9{8'h20}}}) begin
            failures++; $display("FAIL wrap_27_40: got ac=%h l2=%h, required ac=40 l2=%h", ddram_address, line2_text, exp_l2);
        end
        push(1'b0, 7'h41); xfer(1'b0, 8'h14);
        push(1'b0, 7'h40); xfer(1'b0, 8'h10);
        push(1'b0, 7'h40); xfer(1'b0, 8'h08);
        checks++;
        if (display_on !== 1'b0) begin failures++; $display("FAIL display_off: got %b, required 0", display_on); end
        push(1'b0, 7'h40); xfer(1'b0, 8'h0C);
        push(1'b0, 7'h40); xfer(1'b0, 8'h40);
        push(1'b1, 7'h40); xfer(1'b1, 8'h4B);
        checks++;
        if ({display_on, ddram_address, line2_text} !== {1'b1, 7'h40, exp_l2}) begin
            failures++; $display("FAIL cgram_discard: got on=%b ac=%h l2=%h, required on=1 ac=40 l2=%h", display_on, ddram_address, line2_text, exp_l2);
        end
        lcd_rw = 1'b1;
        pulse(1'b1, 1'b1, 8'h55);
        repeat (5) @(negedge clk);
        checks++;
        if ({ddram_address, line2_text} !== {7'h40, exp_l2}) begin
            failures++; $display("FAIL read_ignored: got ac=%h l2=%h, required ac=40 l2=%h", ddram_address, line2_text, exp_l2);
        end
        push(1'b0, 7'h00); xfer(1'b0, 8'h80);
    endtask

    task automatic test_overrun();
        logic ok;
        push(1'b0, 7'h00); pulse(1'b0, 1'b0, 8'h01);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0, 8'h5A);
        wait_busy(1'b0, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok) begin failures++; $display("FAIL overrun_busy_end: busy got %b, required 0", busy); end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag: got %b, required 1", overrun); end
        checks++;
        if ({line1_text, line2_text, ddram_address} !== {ALL_SP, ALL_SP, 7'h00}) begin
            failures++; $display("FAIL overrun_text: got ac=%h l1=%h l2=%h, required ac=00 spaces", ddram_address, line1_text, line2_text);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic ok;
        push(1'b0, 7'h45); xfer(1'b0, 8'hC5);
        push(1'b1, 7'h46); xfer(1'b1, 8'h51);
        push(1'b0, 7'h00); pulse(1'b0, 1'b0, 8'h01);
        wait_busy(1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_clear_start: busy got %b, required 1", busy); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({line1_text, line2_text} !== {ALL_SP, ALL_SP}) begin
            failures++; $display("FAIL mid_rst_text: got l2=%h, required spaces", line2_text);
        end
        checks++;
        if ({busy, ddram_address, display_on, overrun} !== 10'h000) begin
            failures++; $display("FAIL mid_rst_ctrl: got busy=%b ac=%h on=%b ov=%b, required all 0", busy, ddram_address, display_on, overrun);
        end
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL mid_rst_pending: got %0d, required 0", sb.size()); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        lcd_e = 1'b0;
        push(1'b1, 7'h01); xfer(1'b1, 8'h52);
        checks++;
        if ({line1_text, ddram_address} !== {8'h52, {15{8'h20}}, 7'h01}) begin
            failures++; $display("FAIL post_rst_write: got ac=%h l1=%h, required ac=01 l1 starts 52", ddram_address, line1_text);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_vending();
        test_line_end();
        test_decrement();
        test_overrun();
        test_reset_mid_clear();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
